// File: rtl/ksa_pkg.sv
// Shared constants, types and helpers for the pipelined Kogge-Stone adder.
package ksa_pkg;

   localparam int KSA_MAX_WIDTH = 64;

   typedef struct packed {
      logic g;
      logic p;
   } ksa_gp_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/ksa_prefix_cell.sv
// Kogge-Stone black cell: merges a higher (g,p) group with the adjacent lower group.
module ksa_prefix_cell
   import ksa_pkg::*;
(
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g,
   output logic p
);

   ksa_gp_t gp;

   always_comb begin
      gp.g = g_hi | (p_hi & g_lo);
      gp.p = p_hi & p_lo;
   end

   assign g = gp.g;
   assign p = gp.p;

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready on both sides; one rank per prefix level.
// Optional KSA_SUB_EN adds a 'sub' input that turns the operation into a - b.
module ks_adder_pipe
   import ksa_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef KSA_SUB_EN
   input  logic             sub,
`endif
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int LEVELS = clog2(WIDTH);
   localparam int W      = WIDTH;

   if (WIDTH < 2 || WIDTH > KSA_MAX_WIDTH) begin : g_bad_width
      $error("ks_adder_pipe: WIDTH out of range");
   end

   // Prefix vectors are W+1 wide: index 0 carries cin, index i+1 is operand bit i.
   logic [LEVELS:0][W:0]   g_q, g_d;
   logic [LEVELS:0][W:0]   p_q, p_d;
   logic [LEVELS:0][W-1:0] praw_q, praw_d;
   logic [LEVELS:0]        vld_q, vld_d;

   logic [W-1:0] sum_q, sum_d;
   logic         cout_q, cout_d;
   logic         ovf_q, ovf_d;
   logic         out_valid_q, out_valid_d;

   logic [LEVELS:1][W:0] lvl_g;
   logic [LEVELS:1][W:0] lvl_p;

   logic [W-1:0] b_eff;
   logic         cin_eff;
   logic         stall;
   logic         cout_full;
   logic         p_top;
   logic         unused_prefix;

   always_comb begin
`ifdef KSA_SUB_EN
      b_eff   = sub ? ~b : b;
      cin_eff = sub | cin;
`else
      b_eff   = b;
      cin_eff = cin;
`endif
   end

   genvar k, j;
   for (k = 1; k <= LEVELS; k++) begin : g_level
      for (j = 0; j <= W; j++) begin : g_bit
         if (j >= (1 << (k - 1))) begin : g_cell
            ksa_prefix_cell u_cell (
               .g_hi (g_q[k-1][j]),
               .p_hi (p_q[k-1][j]),
               .g_lo (g_q[k-1][j - (1 << (k - 1))]),
               .p_lo (p_q[k-1][j - (1 << (k - 1))]),
               .g    (lvl_g[k][j]),
               .p    (lvl_p[k][j])
            );
         end else begin : g_pass
            assign lvl_g[k][j] = g_q[k-1][j];
            assign lvl_p[k][j] = p_q[k-1][j];
         end
      end
   end

   // When 2^LEVELS == WIDTH the top group stops one short of the cin slot; fold it in here.
   ksa_prefix_cell u_cout_cell (
      .g_hi (g_q[LEVELS][W]),
      .p_hi (p_q[LEVELS][W]),
      .g_lo (g_q[LEVELS][0]),
      .p_lo (p_q[LEVELS][0]),
      .g    (cout_full),
      .p    (p_top)
   );

   assign unused_prefix = ^{p_q[LEVELS][W-1:0], p_top};

   always_comb begin
      stall       = out_valid_q & ~out_ready;
      g_d         = g_q;
      p_d         = p_q;
      praw_d      = praw_q;
      vld_d       = vld_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      if (!stall) begin
         g_d[0]    = {a & b_eff, cin_eff};
         p_d[0]    = {a ^ b_eff, 1'b0};
         praw_d[0] = a ^ b_eff;
         vld_d[0]  = in_valid;
         for (int lv = 1; lv <= LEVELS; lv++) begin
            g_d[lv]    = lvl_g[lv];
            p_d[lv]    = lvl_p[lv];
            praw_d[lv] = praw_q[lv-1];
            vld_d[lv]  = vld_q[lv-1];
         end
         sum_d       = praw_q[LEVELS] ^ g_q[LEVELS][W-1:0];
         cout_d      = cout_full;
         ovf_d       = g_q[LEVELS][W-1] ^ cout_full;
         out_valid_d = vld_q[LEVELS];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_q         <= '0;
         p_q         <= '0;
         praw_q      <= '0;
         vld_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         g_q         <= g_d;
         p_q         <= p_d;
         praw_q      <= praw_d;
         vld_q       <= vld_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = ~stall;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: WIDTH=8 and WIDTH=13 instances against an arithmetic reference model.
module tb_ks_adder_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       iv8, ir8, ov8, ordy8, cin8, cout8, ovf8, sub8;
   logic [7:0] a8, b8, sum8;

   logic        iv13, ir13, ov13, ordy13, cin13, cout13, ovf13, sub13;
   logic [12:0] a13, b13, sum13;

   int n_checks = 0;
   int n_fail   = 0;

   logic [65:0] exp_q [2][$];
   logic        prev_stall [2];
   logic [65:0] prev_out [2];
   int          n_out [2];

   ks_adder_pipe #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
      .a(a8), .b(b8),
`ifdef KSA_SUB_EN
      .sub(sub8),
`endif
      .cin(cin8), .out_valid(ov8), .out_ready(ordy8),
      .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   ks_adder_pipe #(.WIDTH(13)) u13 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv13), .in_ready(ir13),
      .a(a13), .b(b13),
`ifdef KSA_SUB_EN
      .sub(sub13),
`endif
      .cin(cin13), .out_valid(ov13), .out_ready(ordy13),
      .sum(sum13), .cout(cout13), .ovf(ovf13)
   );

   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_msg(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout/unexpected event expected none", name);
   endtask

   // Reference: plain integer addition; subtraction as a + ~b + 1.
   function automatic logic [65:0] model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                         input logic ci, input logic sb);
      logic [64:0] tot;
      logic [63:0] mask, aa, bb, s;
      logic        c, co, o;
      mask = (64'd1 << w) - 64'd1;
      aa   = av & mask;
      bb   = sb ? (~bv & mask) : (bv & mask);
      c    = sb ? 1'b1 : ci;
      tot  = {1'b0, aa} + {1'b0, bb} + {64'd0, c};
      s    = tot[63:0] & mask;
      co   = tot[w];
      o    = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
      return {o, co, s};
   endfunction

   task automatic mon(input int id, input int w, input logic iv, input logic ir, input logic ov,
                      input logic ordy, input logic sb, input logic [63:0] av, input logic [63:0] bv,
                      input logic ci, input logic [63:0] sv, input logic co, input logic of);
      logic [65:0] got, e;
      got = {of, co, sv};
      chk($sformatf("in_ready_rule%0d", w), {65'd0, ir}, {65'd0, !(ov && !ordy)});
      if (prev_stall[id]) begin
         chk($sformatf("stall_valid%0d", w), {65'd0, ov}, 66'd1);
         chk($sformatf("stall_data%0d", w), got, prev_out[id]);
      end
      if (ov && ordy) begin
         if (exp_q[id].size() == 0) fail_msg($sformatf("unexpected_out%0d", w));
         else begin
            e = exp_q[id].pop_front();
            chk($sformatf("result%0d", w), got, e);
            n_out[id]++;
         end
      end
      prev_stall[id] = ov && !ordy;
      prev_out[id]   = got;
      if (iv && ir) exp_q[id].push_back(model(w, av, bv, ci, sb));
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            exp_q[i].delete();
            prev_stall[i] = 1'b0;
         end
      end else begin
         mon(0, 8, iv8, ir8, ov8, ordy8, sub8, {56'd0, a8}, {56'd0, b8}, cin8,
             {56'd0, sum8}, cout8, ovf8);
         mon(1, 13, iv13, ir13, ov13, ordy13, sub13, {51'd0, a13}, {51'd0, b13}, cin13,
             {51'd0, sum13}, cout13, ovf13);
      end
   end

   task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic ci);
      int n;
      a8 = av; b8 = bv; cin8 = ci; iv8 = 1'b1;
      n = 0;
      @(negedge clk);
      while (!ir8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      iv8 = 1'b0;
      if (n >= 50) fail_msg("send8_timeout");
   endtask

   task automatic run8(input string name, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input logic [7:0] es, input logic ec, input logic eo);
      int n;
      send8(av, bv, ci);
      n = 0;
      while (!ov8 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ov8) fail_msg({name, "_timeout"});
      else chk(name, {56'd0, ovf8, cout8, sum8}, {56'd0, eo, ec, es});
      @(posedge clk); #1;
   endtask

   initial begin
      int lat, i, cyc, nacc, base, cnt;
      logic acc;
      rst_n = 1'b0;
      iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; ordy8 = 1; sub8 = 0;
      iv13 = 0; a13 = 0; b13 = 0; cin13 = 0; ordy13 = 1; sub13 = 0;
      for (int q = 0; q < 2; q++) begin
         prev_stall[q] = 1'b0;
         n_out[q] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid8", {65'd0, ov8}, 66'd0);
      chk("reset_sum8", {58'd0, cout8, ovf8, sum8}, 66'd0);
      chk("reset_out_valid13", {65'd0, ov13}, 66'd0);
      chk("reset_in_ready8", {65'd0, ir8}, 66'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency for WIDTH=8: LEVELS(3)+2 = 5 edges
      a8 = 8'h0F; b8 = 8'h01; cin8 = 0; iv8 = 1;
      @(posedge clk); #1;
      iv8 = 0;
      lat = 1;
      while (!ov8 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency8", lat, 5);
      chk("add_0f_01", {56'd0, ovf8, cout8, sum8}, {56'd0, 1'b0, 1'b0, 8'h10});
      @(posedge clk); #1;

      run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run8("add_12_34_c", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
      run8("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      run8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

      // Streaming burst with a 3-cycle downstream stall
      base = n_out[0];
      i = 0; cyc = 0;
      iv8 = 1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      while (i < 20 && cyc < 200) begin
         ordy8 = !(cyc >= 10 && cyc < 13);
         @(negedge clk);
         if (!ordy8 && ov8) chk("stall_in_ready8", {65'd0, ir8}, 66'd0);
         acc = ir8;
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            i++;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         end
      end
      iv8 = 0; ordy8 = 1;
      repeat (10) @(posedge clk);
      #1;
      chk("stream8_count", n_out[0] - base, 20);

      // Latency for WIDTH=13: LEVELS(4)+2 = 6 edges
      a13 = 13'h1FFF; b13 = 13'h0001; cin13 = 1; iv13 = 1;
      @(posedge clk); #1;
      iv13 = 0;
      lat = 1;
      while (!ov13 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency13", lat, 6);
      chk("add13_1fff_1_c", {51'd0, ovf13, cout13, sum13}, {51'd0, 1'b0, 1'b1, 13'h0001});
      @(posedge clk); #1;

      nacc = 0; cyc = 0;
      while (nacc < 1000 && cyc < 20000) begin
         iv13 = ($urandom_range(3) != 0);
         ordy13 = ($urandom_range(2) != 0);
         a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
         @(negedge clk);
         acc = iv13 && ir13;
         @(posedge clk); #1;
         cyc++;
         if (acc) nacc++;
      end
      iv13 = 0; ordy13 = 1;
      repeat (12) @(posedge clk);
      #1;
      chk("rand13_accepted", nacc, 1000);
      chk("rand13_drained", n_out[1], 1001);

      // Reset with results in flight and one held at the output
      ordy8 = 0;
      send8(8'h01, 8'h02, 1'b0);
      send8(8'h03, 8'h04, 1'b0);
      send8(8'h05, 8'h06, 1'b0);
      send8(8'h07, 8'h08, 1'b0);
      cnt = 0;
      while (!ov8 && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("inflight_out_valid8", {65'd0, ov8}, 66'd1);
      #2 rst_n = 0;
      #1 chk("async_reset_out_valid8", {65'd0, ov8}, 66'd0);
      @(posedge clk); #1;
      rst_n = 1; ordy8 = 1;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (ov8) cnt++;
      end
      @(posedge clk); #1;
      chk("no_stale_after_reset", cnt, 0);
      run8("post_reset_add", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

`ifdef KSA_SUB_EN
      sub8 = 1;
      run8("sub_05_07", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
      run8("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
      sub8 = 0;
`endif

      repeat (10) @(posedge clk);
      #1;
      chk("queue8_empty", exp_q[0].size(), 0);
      chk("queue13_empty", exp_q[1].size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
